// File: rtl/net_injector_pkg.sv
// Shared definitions for the multi-VC network injector: per-VC route state
// encoding, flit type codes and the statistics counter width.
package net_injector_pkg;

    // Per-VC route state, 2-bit encoding.
    typedef enum logic [1:0] {
        ROUTE_IDLE   = 2'd0,
        ROUTE_REMOTE = 2'd1,
        ROUTE_LOCAL  = 2'd2
    } route_state_e;

    // Flit type codes (`header, `body, `tail, `header_tail).
    localparam logic [1:0] FLIT_HEADER      = 2'b00;
    localparam logic [1:0] FLIT_BODY        = 2'b01;
    localparam logic [1:0] FLIT_TAIL        = 2'b10;
    localparam logic [1:0] FLIT_HEADER_TAIL = 2'b11;

    localparam int STATS_WIDTH = 32;

    // Saturating increment for the statistics counters.
    function automatic logic [STATS_WIDTH-1:0] sat_inc(input logic [STATS_WIDTH-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/injector_local_fifo.sv
// Synchronous FIFO for the local delivery port. valid/ready on both sides;
// a push is refused whenever the FIFO is full, even if a pop happens in the
// same cycle. The head entry is visible the cycle after it was pushed.
module injector_local_fifo
    import net_injector_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_WIDTH-1:0]          in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count_q;
    logic                  full;
    logic                  push;
    logic                  pop;

    assign full      = (count_q == CW'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = (count_q != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && !full;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/network_injector_mvc.sv
// Multi-VC network injector. Keeps a route state per VC so packets on
// different VCs may interleave flit by flit; steers each flit either to the
// router (avail/valid, zero latency) or into a local FIFO (valid/ready).
// Optional statistics counters are built when NETWORK_INJECTOR_STATS_EN is
// defined; otherwise the stat outputs are constant zero.
//
// Handshakes: an input flit transfers when tlp_valid_i && tlp_ready_o. The
// router side transfers whenever network_valid_o is high (the router already
// advertised room via network_avail_i for that VC). The local side transfers
// when local_valid_o && local_ready_i.
module network_injector_mvc
    import net_injector_pkg::*;
#(
    parameter int NetworkIfAddressId               = 0,
    parameter int NetworkIfFlitWidth               = 64,
    parameter int NetworkIfFlitTypeWidth           = 2,
    parameter int NetworkIfBroadcastWidth          = 1,
    parameter int NetworkIfVirtualChannelIdWidth   = 2,
    parameter int NetworkIfVirtualNetworkIdWidth   = 2,
    parameter int NetworkIfNumberOfVirtualChannels = 4,
    parameter int VirtualChannelsPerNetwork        = 1,
    parameter int DestinationMsb                   = 63,
    parameter int DestinationLsb                   = 53,
    parameter int LocalFifoDepth                   = 4
) (
    input  logic                                        clk_i,
    input  logic                                        rst_i,
    input  logic                                        tlp_valid_i,
    output logic                                        tlp_ready_o,
    input  logic [NetworkIfFlitWidth-1:0]               tlp_flit_i,
    input  logic [NetworkIfFlitTypeWidth-1:0]           tlp_flit_type_i,
    input  logic [NetworkIfBroadcastWidth-1:0]          tlp_broadcast_i,
    input  logic [NetworkIfVirtualChannelIdWidth-1:0]   tlp_virtual_channel_id_i,
    output logic                                        network_valid_o,
    input  logic [NetworkIfNumberOfVirtualChannels-1:0] network_avail_i,
    output logic [NetworkIfFlitWidth-1:0]               network_flit_o,
    output logic [NetworkIfFlitTypeWidth-1:0]           network_flit_type_o,
    output logic [NetworkIfBroadcastWidth-1:0]          network_broadcast_o,
    output logic [NetworkIfVirtualChannelIdWidth-1:0]   network_virtual_channel_id_o,
    output logic                                        local_valid_o,
    input  logic                                        local_ready_i,
    output logic [NetworkIfFlitWidth-1:0]               local_flit_o,
    output logic [NetworkIfFlitTypeWidth-1:0]           local_flit_type_o,
    output logic [NetworkIfBroadcastWidth-1:0]          local_broadcast_o,
    output logic [NetworkIfVirtualNetworkIdWidth-1:0]   local_virtual_network_id_o,
    output logic [$clog2(LocalFifoDepth+1)-1:0]         local_fifo_count_o,
    output logic                                        protocol_error_o,
    output logic [STATS_WIDTH-1:0]                      stat_remote_flits_o,
    output logic [STATS_WIDTH-1:0]                      stat_local_flits_o,
    output logic [STATS_WIDTH-1:0]                      stat_dropped_flits_o
);

    localparam int NUM_VC  = NetworkIfNumberOfVirtualChannels;
    localparam int DEST_W  = DestinationMsb - DestinationLsb + 1;
    localparam int FT_W    = NetworkIfFlitTypeWidth;
    localparam int VN_W    = NetworkIfVirtualNetworkIdWidth;
    localparam int ENTRY_W = NetworkIfFlitWidth + FT_W + NetworkIfBroadcastWidth + VN_W;

    route_state_e vc_state_q [NUM_VC];
    route_state_e vc_state_d [NUM_VC];

    route_state_e cur_state;
    route_state_e route;
    logic         is_header;
    logic         to_local;
    logic         drop;
    logic         fifo_in_ready;
    logic         fifo_push;
    logic         accept;
    logic         drop_fire;
    logic         error_set;
    logic         error_q;
    logic [VN_W-1:0]    vn;
    logic [ENTRY_W-1:0] fifo_out_data;

    // Route decision for the flit currently offered, plus ready/valid terms.
    always_comb begin
        cur_state = vc_state_q[tlp_virtual_channel_id_i];
        is_header = (tlp_flit_type_i == FT_W'(FLIT_HEADER)) ||
                    (tlp_flit_type_i == FT_W'(FLIT_HEADER_TAIL));
        to_local  = (tlp_flit_i[DestinationMsb:DestinationLsb] == DEST_W'(NetworkIfAddressId)) &&
                    (tlp_broadcast_i == '0);
        route     = cur_state;
        drop      = 1'b0;
        if (is_header) begin
            route = to_local ? ROUTE_LOCAL : ROUTE_REMOTE;
        end else if (cur_state == ROUTE_IDLE) begin
            drop = 1'b1;
        end

        network_valid_o = tlp_valid_i && (route == ROUTE_REMOTE) && !drop &&
                          network_avail_i[tlp_virtual_channel_id_i];
        fifo_push       = tlp_valid_i && (route == ROUTE_LOCAL) && !drop && fifo_in_ready;
        tlp_ready_o     = drop ||
                          ((route == ROUTE_REMOTE) && network_avail_i[tlp_virtual_channel_id_i]) ||
                          ((route == ROUTE_LOCAL) && fifo_in_ready);
        accept          = tlp_valid_i && tlp_ready_o && !drop;
        drop_fire       = tlp_valid_i && drop;
        error_set       = drop_fire || (accept && is_header && (cur_state != ROUTE_IDLE));
        vn              = VN_W'(32'(tlp_virtual_channel_id_i) / 32'(VirtualChannelsPerNetwork));
    end

    // Next per-VC route state: only the VC of an accepted flit moves.
    always_comb begin
        for (int i = 0; i < NUM_VC; i++) begin
            vc_state_d[i] = vc_state_q[i];
        end
        if (accept) begin
            case (tlp_flit_type_i)
                FT_W'(FLIT_HEADER):      vc_state_d[tlp_virtual_channel_id_i] = route;
                FT_W'(FLIT_HEADER_TAIL): vc_state_d[tlp_virtual_channel_id_i] = ROUTE_IDLE;
                FT_W'(FLIT_TAIL):        vc_state_d[tlp_virtual_channel_id_i] = ROUTE_IDLE;
                default:                 vc_state_d[tlp_virtual_channel_id_i] = cur_state;
            endcase
        end
    end

    // Per-VC route state register and sticky protocol error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_VC; i++) begin
                vc_state_q[i] <= ROUTE_IDLE;
            end
            error_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_VC; i++) begin
                vc_state_q[i] <= vc_state_d[i];
            end
            if (error_set) begin
                error_q <= 1'b1;
            end
        end
    end

    assign protocol_error_o             = error_q;
    assign network_flit_o               = tlp_flit_i;
    assign network_flit_type_o          = tlp_flit_type_i;
    assign network_broadcast_o          = tlp_broadcast_i;
    assign network_virtual_channel_id_o = tlp_virtual_channel_id_i;

    injector_local_fifo #(
        .DEPTH      (LocalFifoDepth),
        .DATA_WIDTH (ENTRY_W)
    ) u_local_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .in_valid  (fifo_push),
        .in_ready  (fifo_in_ready),
        .in_data   ({tlp_flit_i, tlp_flit_type_i, tlp_broadcast_i, vn}),
        .out_valid (local_valid_o),
        .out_ready (local_ready_i),
        .out_data  (fifo_out_data),
        .count     (local_fifo_count_o)
    );

    assign {local_flit_o, local_flit_type_o, local_broadcast_o, local_virtual_network_id_o} = fifo_out_data;

`ifdef NETWORK_INJECTOR_STATS_EN
    logic [STATS_WIDTH-1:0] stat_remote_q;
    logic [STATS_WIDTH-1:0] stat_local_q;
    logic [STATS_WIDTH-1:0] stat_dropped_q;

    // Saturating traffic counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_remote_q  <= '0;
            stat_local_q   <= '0;
            stat_dropped_q <= '0;
        end else begin
            if (network_valid_o) stat_remote_q  <= sat_inc(stat_remote_q);
            if (fifo_push)       stat_local_q   <= sat_inc(stat_local_q);
            if (drop_fire)       stat_dropped_q <= sat_inc(stat_dropped_q);
        end
    end

    assign stat_remote_flits_o  = stat_remote_q;
    assign stat_local_flits_o   = stat_local_q;
    assign stat_dropped_flits_o = stat_dropped_q;
`else
    assign stat_remote_flits_o  = '0;
    assign stat_local_flits_o   = '0;
    assign stat_dropped_flits_o = '0;
`endif

endmodule

// File: tb/tb_network_injector_mvc.sv
// Testbench for network_injector_mvc: directed steps followed by random
// traffic, checked against a packet-level reference model.
module tb_network_injector_mvc;

    localparam int ADDR_ID = 0;
    localparam int DEPTH   = 4;
    localparam logic [1:0] HDR = 2'b00, BODY = 2'b01, TAIL = 2'b10, HT = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tlp_valid = 1'b0;
    logic        tlp_ready;
    logic [63:0] tlp_flit = '0;
    logic [1:0]  tlp_type = '0;
    logic        tlp_bcast = 1'b0;
    logic [1:0]  tlp_vc = '0;
    logic        net_valid;
    logic [3:0]  net_avail = '0;
    logic [63:0] net_flit;
    logic [1:0]  net_type;
    logic        net_bcast;
    logic [1:0]  net_vc;
    logic        loc_valid;
    logic        loc_ready = 1'b0;
    logic [63:0] loc_flit;
    logic [1:0]  loc_type;
    logic        loc_bcast;
    logic [1:0]  loc_vn;
    logic [2:0]  loc_count;
    logic        perr;
    logic [31:0] st_rem, st_loc, st_drop;

    network_injector_mvc #(
        .NetworkIfAddressId (ADDR_ID),
        .LocalFifoDepth     (DEPTH)
    ) dut (
        .clk_i                        (clk),
        .rst_i                        (rst),
        .tlp_valid_i                  (tlp_valid),
        .tlp_ready_o                  (tlp_ready),
        .tlp_flit_i                   (tlp_flit),
        .tlp_flit_type_i              (tlp_type),
        .tlp_broadcast_i              (tlp_bcast),
        .tlp_virtual_channel_id_i     (tlp_vc),
        .network_valid_o              (net_valid),
        .network_avail_i              (net_avail),
        .network_flit_o               (net_flit),
        .network_flit_type_o          (net_type),
        .network_broadcast_o          (net_bcast),
        .network_virtual_channel_id_o (net_vc),
        .local_valid_o                (loc_valid),
        .local_ready_i                (loc_ready),
        .local_flit_o                 (loc_flit),
        .local_flit_type_o            (loc_type),
        .local_broadcast_o            (loc_bcast),
        .local_virtual_network_id_o   (loc_vn),
        .local_fifo_count_o           (loc_count),
        .protocol_error_o             (perr),
        .stat_remote_flits_o          (st_rem),
        .stat_local_flits_o           (st_loc),
        .stat_dropped_flits_o         (st_drop)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Reference model: open packets per VC, where they go, local queue.
    bit          vc_open  [4];
    bit          vc_local [4];
    bit          m_err;
    int          m_rem, m_loc, m_drop;
    logic [68:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            vc_open[i]  = 1'b0;
            vc_local[i] = 1'b0;
        end
        m_err  = 1'b0;
        m_rem  = 0;
        m_loc  = 0;
        m_drop = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        tlp_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Offer one flit for one cycle, check all outputs, then advance the model.
    task automatic step(input logic v, input int vc, input logic [1:0] ft, input bit to_me,
                        input logic bc, input logic [3:0] av, input logic lr);
        logic [63:0] f;
        logic [10:0] d;
        bit hdr, drop, to_loc, exp_rdy, exp_nv;
        @(negedge clk);
        f = {$urandom, $urandom};
        d = to_me ? 11'(ADDR_ID) : 11'($urandom_range(1, 2047));
        f[63:53]  = d;
        tlp_valid = v;
        tlp_vc    = 2'(vc);
        tlp_type  = ft;
        tlp_bcast = bc;
        tlp_flit  = f;
        net_avail = av;
        loc_ready = lr;
        #1;
        hdr    = (ft == HDR) || (ft == HT);
        drop   = 1'b0;
        to_loc = 1'b0;
        if (hdr) to_loc = (d == 11'(ADDR_ID)) && !bc;
        else if (!vc_open[vc]) drop = 1'b1;
        else to_loc = vc_local[vc];
        exp_rdy = drop ? 1'b1 : (to_loc ? (exp_q.size() < DEPTH) : av[vc]);
        exp_nv  = v && !drop && !to_loc && av[vc];

        check("local_valid", loc_valid, exp_q.size() > 0);
        check("local_count", loc_count, exp_q.size());
        if (exp_q.size() > 0)
            check("local_entry", {loc_flit, loc_type, loc_bcast, loc_vn}, exp_q[0]);
        check("protocol_error", perr, m_err);
`ifdef NETWORK_INJECTOR_STATS_EN
        check("stat_remote", st_rem, m_rem);
        check("stat_local", st_loc, m_loc);
        check("stat_dropped", st_drop, m_drop);
`else
        check("stat_remote", st_rem, 0);
        check("stat_local", st_loc, 0);
        check("stat_dropped", st_drop, 0);
`endif
        if (v) check("tlp_ready", tlp_ready, exp_rdy);
        check("network_valid", net_valid, exp_nv);
        if (exp_nv) check("network_fields", {net_flit, net_type, net_bcast, net_vc}, {f, ft, bc, 2'(vc)});

        @(posedge clk);
        if (exp_q.size() > 0 && lr) void'(exp_q.pop_front());
        if (v && exp_rdy) begin
            if (drop) begin
                m_err = 1'b1;
                m_drop++;
            end else begin
                if (hdr && vc_open[vc]) m_err = 1'b1;
                if (ft == HDR) begin
                    vc_open[vc]  = 1'b1;
                    vc_local[vc] = to_loc;
                end else if (ft != BODY) begin
                    vc_open[vc] = 1'b0;
                end
                if (to_loc) begin
                    exp_q.push_back({f, ft, bc, 2'(vc)});
                    m_loc++;
                end else begin
                    m_rem++;
                end
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();
        // Reset state.
        step(0, 0, HDR, 0, 0, 4'b0000, 0);

        // VC1 remote packet with only VC1 available.
        step(1, 1, HDR,  0, 0, 4'b0010, 1);
        step(1, 1, BODY, 0, 0, 4'b0010, 1);
        step(1, 1, TAIL, 0, 0, 4'b0010, 1);
        step(0, 1, BODY, 0, 0, 4'b0010, 1);

        // VC0 single-flit local packet, then drain.
        step(1, 0, HT, 1, 0, 4'b1111, 1);
        step(0, 0, HDR, 0, 0, 4'b1111, 1);
        step(0, 0, HDR, 0, 0, 4'b1111, 1);

        // Broadcast header addressed to us goes remote.
        step(1, 2, HT, 1, 1, 4'b0100, 1);

        // Interleaved VC0 local and VC2 remote packets.
        step(1, 0, HDR,  1, 0, 4'b1111, 1);
        step(1, 2, HDR,  0, 0, 4'b1111, 1);
        step(1, 0, BODY, 0, 0, 4'b1111, 1);
        step(1, 2, BODY, 1, 0, 4'b1111, 1);
        step(1, 0, TAIL, 0, 0, 4'b1111, 1);
        step(1, 2, TAIL, 1, 0, 4'b1111, 1);
        step(0, 0, HDR, 0, 0, 4'b1111, 1);
        step(0, 0, HDR, 0, 0, 4'b1111, 1);

        // Fill the local FIFO with the sink stalled, fifth flit refused.
        step(1, 0, HDR,  1, 0, 4'b1111, 0);
        step(1, 0, BODY, 0, 0, 4'b1111, 0);
        step(1, 0, BODY, 0, 0, 4'b1111, 0);
        step(1, 0, BODY, 0, 0, 4'b1111, 0);
        step(1, 0, BODY, 0, 0, 4'b1111, 0);
        repeat (5) step(0, 0, HDR, 0, 0, 4'b1111, 1);
        step(1, 0, TAIL, 0, 0, 4'b1111, 1);
        step(0, 0, HDR, 0, 0, 4'b1111, 1);

        // Body on idle VC3 is dropped and flags the error.
        step(1, 3, BODY, 0, 0, 4'b1111, 1);
        step(0, 3, BODY, 0, 0, 4'b1111, 1);

        // Header on an open VC is re-routed and flags the error.
        do_reset();
        step(1, 1, HDR, 0, 0, 4'b1111, 1);
        step(1, 1, HDR, 1, 0, 4'b1111, 1);
        step(1, 1, TAIL, 0, 0, 4'b1111, 1);
        step(0, 1, TAIL, 0, 0, 4'b1111, 1);

        // Reset mid-packet with two flits buffered.
        do_reset();
        step(1, 1, HDR,  0, 0, 4'b1111, 0);
        step(1, 0, HDR,  1, 0, 4'b1111, 0);
        step(1, 0, BODY, 0, 0, 4'b1111, 0);
        do_reset();
        step(0, 0, HDR,  0, 0, 4'b1111, 1);
        step(1, 0, BODY, 0, 0, 4'b1111, 1);
        step(1, 1, TAIL, 0, 0, 4'b1111, 1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3), 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0);
        end
        step(0, 0, HDR, 0, 0, 4'b0000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/network_injector_mvc.md
Name: network_injector_mvc

Overview:
Multi-VC successor of the network injector. Accepts transport-layer flits (valid/ready) on any virtual channel and keeps a per-VC route state, so packets on different VCs may interleave flit by flit. Each flit is steered to the router port (avail/valid NoC handshake) or to a buffered local port (valid/ready). The block sits between the Tonet arbiter and the router injection port.

Parameters:
NetworkIfAddressId, 0, address of this network interface.
NetworkIfFlitWidth, 64, flit width in bits.
NetworkIfFlitTypeWidth, 2, flit type width.
NetworkIfBroadcastWidth, 1, broadcast field width.
NetworkIfVirtualChannelIdWidth, 2, VC id width.
NetworkIfVirtualNetworkIdWidth, 2, VN id width.
NetworkIfNumberOfVirtualChannels, 4, VC count; must be <= 2^VirtualChannelIdWidth.
VirtualChannelsPerNetwork, 1, VC-to-VN divisor; vn = vc / VirtualChannelsPerNetwork.
DestinationMsb, 63, MSB of the destination field in the header flit.
DestinationLsb, 53, LSB of the destination field in the header flit.
LocalFifoDepth, 4, local buffer depth; power of 2, >= 2.

Ports:
clk_i in 1 clock
rst_i in 1 synchronous active-high reset
tlp_valid_i in 1 input flit valid
tlp_ready_o out 1 input flit accepted
tlp_flit_i in FlitWidth flit payload
tlp_flit_type_i in FlitTypeWidth flit type (`header, `body, `tail, `header_tail)
tlp_broadcast_i in BroadcastWidth broadcast field
tlp_virtual_channel_id_i in VirtualChannelIdWidth VC of the flit
network_valid_o out 1 NoC flit valid
network_avail_i in NumberOfVirtualChannels per-VC availability
network_flit_o, network_flit_type_o, network_broadcast_o, network_virtual_channel_id_o out (matching widths) pass-through of the inputs
local_valid_o out 1 local flit valid
local_ready_i in 1 local sink ready
local_flit_o, local_flit_type_o, local_broadcast_o out (matching widths) local flit fields
local_virtual_network_id_o out VirtualNetworkIdWidth computed VN
local_fifo_count_o out clog2(LocalFifoDepth+1) local buffer occupancy
protocol_error_o out 1 sticky protocol error
stat_remote_flits_o, stat_local_flits_o, stat_dropped_flits_o out 32 each statistics counters

Behaviour:
- Reset: all per-VC states IDLE; FIFO empty; local_valid_o=0, local_fifo_count_o=0, protocol_error_o=0, all stats=0. Reset mid-packet discards the route state and the FIFO contents.
- Per-VC state: IDLE / REMOTE / LOCAL, 2-bit encoding.
- Header classification: local when the destination field == NetworkIfAddressId and tlp_broadcast_i == 0; otherwise remote.
- Route selection:
  - Header flits use the classification.
  - body/tail flits use the state of their VC.
  - body/tail on an IDLE VC is a drop: tlp_ready_o=1, flit discarded, protocol_error_o set.
- Network path (combinational, zero latency):
  - network_valid_o = tlp_valid_i & route==remote & network_avail_i[vc].
  - Ready uses the same terms. network_valid_o is never asserted without avail of the same VC.
- Local path:
  - Push when route==local & tlp_valid_i & FIFO not full.
  - Full blocks the push even if a pop happens in the same cycle.
  - Head is visible on local_valid_o the cycle after the push (1-cycle latency).
  - Pop on local_valid_o & local_ready_i. Simultaneous push and pop when not full: count unchanged.
- State update, on the handshake only (tlp_valid_i & tlp_ready_o, excluding drops):
  - header → REMOTE or LOCAL.
  - header_tail → IDLE.
  - tail → IDLE.
  - body → unchanged.
- A header arriving on a non-IDLE VC: accepted and re-routed; protocol_error_o set.
- protocol_error_o clears only on reset.
- VN id: vc / VirtualChannelsPerNetwork, truncated to VirtualNetworkIdWidth.

Optional Feature:
NETWORK_INJECTOR_STATS_EN
- Defined: three 32-bit saturating counters, each incremented once per accepted remote flit, pushed local flit, and dropped flit respectively.
- Undefined: stat outputs tied to 0 and no counter flops are synthesised.

Decomposition:
- Shared package net_injector_pkg holds:
  - route state encodings (IDLE/REMOTE/LOCAL);
  - flit-type localparams mirroring `header/`body/`tail/`header_tail;
  - the stats counter width.
- Sub-module injector_local_fifo: synchronous FIFO with valid/ready on both sides and a count output, holding {flit, type, broadcast, vn}.

Test Plan:
- VC1 remote header (dest≠Id), then body, then tail, with avail=4'b0010 → network_valid_o asserted on 3 cycles; VC1 back to IDLE; no local output.
- VC0 local header_tail (dest==Id), local_ready_i=1 → local_valid_o high one cycle later; VN=0; count goes 1→0.
- Interleaved VC0 local packet and VC2 remote packet, flit by flit → each flit appears on the correct port; no route mixing.
- local_ready_i=0 with 5 local flits, depth 4 → 4 accepted, count=4, tlp_ready_o=0 on the 5th; release → 4 pops in order.
- body on an IDLE VC3 → tlp_ready_o=1, no output, protocol_error_o=1, stat_dropped_flits_o=1 (with NETWORK_INJECTOR_STATS_EN).
- rst_i asserted mid-packet with the FIFO holding 2 flits → next cycle count=0, local_valid_o=0, all VCs IDLE.
